// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO access arbiter: read-side state
// encoding and the index-width helper used for producer pointers.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } rd_state_t;

    // A single producer still needs a 1-bit index field.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_access_arbiter_rr.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    int w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!any && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = PW'(w_idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Shares one FIFO between NREQ producers (round-robin push side) and drains it
// toward a single consumer through a registered valid/ready output stage.
//
// state | meaning
// IDLE  | nothing in flight, waiting for the FIFO to go non-empty
// WAIT  | pop issued last cycle, poppedValue arrives now
// HOLD  | out_data valid, waiting for the consumer to take it
module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int width = 4,
    localparam int PW   = clog2_min1(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*width-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [PW-1:0]           grant_id,
    output logic                    push,
    output logic [width-1:0]        pushedValue,
    input  logic                    full,
    output logic                    pop,
    input  logic                    empty,
    input  logic [width-1:0]        poppedValue,
    output logic                    out_valid,
    output logic [width-1:0]        out_data,
    input  logic                    out_ready
);

    logic [PW-1:0]    r_prio_ptr;
    logic [PW-1:0]    r_grant_id;
    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic             r_out_valid;
    logic [width-1:0] r_out_data;

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_any;
    logic             w_pop;

    // Masking the request vector keeps push/req_ready low under reset or full.
    assign w_elig = (reset && !full) ? req_valid : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req     (w_elig),
        .ptr     (r_prio_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign req_ready   = w_gnt;
    assign push        = w_any;
    assign pushedValue = req_data[int'(w_gnt_idx)*width +: width];
    assign grant_id    = r_grant_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prio_ptr <= '0;
            r_grant_id <= '0;
        end else if (w_any) begin
            r_grant_id <= w_gnt_idx;
            r_prio_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: w_state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
                    if (!empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!reset) w_pop = 1'b0;
    end

    assign pop = w_pop;

    // A word in flight when reset hits is dropped; WAIT never completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == WAIT) begin
                r_out_data  <= poppedValue;
                r_out_valid <= 1'b1;
            end else if (r_state == HOLD && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: doc/fifo_access_arbiter.md
Name: fifo_access_arbiter

Overview:
- Controller that shares one FIFO (push/pop, full/empty, pushedValue/poppedValue interface) between NREQ producers and sequences its read side toward one consumer.
- Write side: round-robin arbiter granting at most one producer per cycle.
- Read side: small FSM that issues pops, absorbs the FIFO's 1-cycle read latency and presents a registered valid/ready output.
- Sits between producer blocks and the FIFO instance, and between the FIFO and the downstream consumer.

Parameters:
- NREQ, 4, number of producers (2..8)
- width, 4, data width; matches FIFO width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low; all state cleared on the rising clk edge where reset==0
- req_valid  in  NREQ  producer i has a word to push
- req_data  in  NREQ*width  producer i word at bits [i*width +: width]
- req_ready  out  NREQ  one-hot; word of producer i accepted this cycle
- grant_id  out  $clog2(NREQ)  index of last granted producer (registered)
- push  out  1  FIFO write strobe
- pushedValue  out  width  FIFO write data
- full  in  1  FIFO full
- pop  out  1  FIFO read strobe
- empty  in  1  FIFO empty
- poppedValue  in  width  FIFO read data; valid the cycle after pop
- out_valid  out  1  out_data holds a word
- out_data  out  width  registered output word
- out_ready  in  1  consumer accepts out_data

Behaviour:
- Reset values (reset==0 at the clk edge):
  - prio_ptr=0, grant_id=0, read FSM=IDLE, out_valid=0, out_data=0.
  - Combinational outputs are forced low while reset==0: push=0, pop=0, req_ready=0.
- Write arbitration (combinational grant, registered pointer):
  - Eligible set = req_valid, masked to 0 when full==1.
  - Search starts at index prio_ptr and wraps modulo NREQ; the first eligible index i wins.
  - On a win: req_ready[i]=1, push=1, pushedValue=req_data[i].
  - After a grant to i: prio_ptr<=(i+1) mod NREQ, grant_id<=i. With no grant, both hold.
  - req_ready may depend on req_valid in the same cycle. Producers must hold valid and data until ready.
  - full==1 means no req_ready and no push. A push issued while full is a bug; assert never.
- Read FSM (enum IDLE, WAIT, HOLD):
  - IDLE: if !empty, pop=1 and go to WAIT; otherwise stay.
  - WAIT: out_data<=poppedValue, out_valid<=1, go to HOLD. pop=0.
  - HOLD, out_ready==0: hold out_data/out_valid, stay.
  - HOLD, out_ready==1 and !empty: pop=1, out_valid<=0, go to WAIT (back-to-back; peak 1 word per 2 cycles).
  - HOLD, out_ready==1 and empty: out_valid<=0, go to IDLE.
  - pop is issued only in IDLE/HOLD with empty==0. Never pop while empty.
- Simultaneous events:
  - push and pop in the same cycle are allowed and independent.
  - A push into an empty FIFO becomes visible via empty==0 on a later cycle; the FSM reacts when empty deasserts.
- Reset mid-operation: an in-flight pop's data is discarded. The FSM returns to IDLE and out_valid goes to 0 the same edge. The word is lost; this is accepted behaviour.
- Wrap-around: prio_ptr wraps NREQ-1 -> 0. Every requester held valid with the FIFO never full is granted within NREQ cycles.

Decomposition:
- fifo_arb_pkg:
  - read FSM state enum (IDLE, WAIT, HOLD)
  - function clog2_min1(n) for the grant_id/prio_ptr width (minimum 1)
- Sub-module rr_arbiter #(NREQ): inputs req[NREQ], ptr; outputs gnt one-hot, gnt_idx, any. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all req_valid=1 and empty=0 -> push=0, pop=0, req_ready=0, out_valid=0, grant_id=0. Release -> cycle 1 grants req 0.
- Round-robin: req_valid=4'b1111, data i=i+1, full=0 for 8 cycles -> pushedValue sequence 1,2,3,4,1,2,3,4; req_ready one-hot, rotating.
- Skip and wrap: prio_ptr=3, req_valid=4'b0101 -> grant 0, then 2, then 0. grant_id tracks.
- Full backpressure: full=1 for 3 cycles with req_valid=4'b0010 -> no push, req_ready=0. full=0 -> push of req_data[1] the same cycle.
- Read sequencing: FIFO model holds 3,9 with out_ready=1 -> pop at t, out_data=3/out_valid at t+2, pop at t+2, out_data=9 at t+4, then IDLE when empty. With out_ready=0, out_data=3 holds indefinitely and no further pop.
- Reset in WAIT: reset=0 the cycle after pop -> out_valid stays 0, FSM in IDLE, poppedValue ignored; next !empty triggers a fresh pop.
